fib_seq_ctrl: RTL and testbench
===============================

Name: fib_seq_ctrl

Overview:
- Controller/sequencer directly upstream of the datapath ALU in the Fibonacci FSM design.
- Drives the ALU opcode and both operand buses, and consumes the ALU result O and zero_flag.
- Holds the running terms and the term counter; emits one Fibonacci term per valid pulse.
- All arithmetic (add, decrement, zero test) is done through the external ALU, never locally.

Parameters:
- WIDTH, 4, data width of ALU operands, result, terms, and counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a run; sampled only in IDLE
- n_in  in  WIDTH  number of terms to emit; latched on accepted start
- alu_opcode  out  3  opcode to ALU
- alu_a  out  WIDTH  ALU operand A
- alu_b  out  WIDTH  ALU operand B
- alu_o  in  WIDTH  ALU result O (combinational, same cycle)
- alu_zero  in  1  ALU zero_flag (O == 0)
- fib_out  out  WIDTH  current term, registered
- valid  out  1  fib_out holds a new term this cycle
- busy  out  1  run in progress
- done  out  1  one-cycle end-of-run pulse
- overflow  out  1  sticky: a term sum exceeded WIDTH bits this run

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - State = IDLE.
  - alu_opcode = OP_PASSA; alu_a = alu_b = 0.
  - fib_out = 0; valid = busy = done = overflow = 0.
  - Internal cnt, f_prev, f_cur = 0.
- Reset mid-run aborts immediately to these values; no done pulse is produced.
- IDLE:
  - ALU driven OP_PASSA, a = b = 0.
  - start = 1 at a clk edge: cnt <= n_in, f_prev <= 0, f_cur <= 1, overflow <= 0, go to CHECK.
- CHECK:
  - Drive OP_PASSA, a = cnt, b = 0.
  - alu_zero = 1 -> DONE; else -> EMIT.
- EMIT:
  - fib_out register holds f_prev; valid = 1 only in this state.
  - Drive OP_ADD, a = f_prev, b = f_cur.
  - At the edge: f_prev <= f_cur, f_cur <= alu_o.
  - Carry detect: alu_o < alu_a (unsigned) sets overflow.
  - Next state -> DEC (see Optional Feature).
- DEC:
  - Drive OP_SUB, a = cnt, b = 1.
  - cnt <= alu_o; go to CHECK.
- DONE:
  - done = 1 for exactly one cycle, then -> IDLE.
- busy = 1 in every state except IDLE.
- fib_out is loaded with f_prev on the edge entering EMIT and holds its value until the next EMIT.
- Timing:
  - Three cycles per term (CHECK, EMIT, DEC).
  - First valid is 2 cycles after the accepted start edge.
  - done is asserted 3·n_in + 2 cycles after the start edge.
- n_in = 0: CHECK -> DONE with no valid pulse.
- start while busy: ignored; n_in changes while busy: ignored.
- All arithmetic is modulo 2^WIDTH.

Optional Feature:
- Macro: FIB_OVF_STOP_EN.
- Defined: an EMIT cycle that sets overflow goes EMIT -> DONE. The term in that EMIT is still valid; later terms are suppressed; overflow stays 1.
- Undefined: overflow is set sticky only; the sequence continues, wrapping modulo 2^WIDTH, until cnt reaches 0.

Decomposition:
- Package fib_pkg holds:
  - ALU opcode constants: OP_PASSA = 3'b000, OP_ADD = 3'b010, OP_SUB = 3'b011. These are shared with the ALU.
  - State encoding: IDLE, CHECK, EMIT, DEC, DONE.
  - Default WIDTH.
- Single module; no sub-module is natural. The FSM and its three registers are one unit.

Test Plan:
- Reset: hold rst_n = 0 during a run -> all outputs 0, state IDLE; releasing reset produces no spurious done.
- n_in = 3, start pulsed at edge 0 -> valid in cycles 2, 5, 8 with fib_out 0, 1, 1; done in cycle 11; busy in cycles 1–11.
- n_in = 0 -> no valid; done in cycle 2; alu_opcode = OP_PASSA with alu_a = 0 in cycle 1.
- n_in = 10, macro undefined -> terms 0, 1, 1, 2, 3, 5, 8, 13, 5, 2; overflow rises in the EMIT of 8.
- n_in = 10, FIB_OVF_STOP_EN defined -> terms 0, 1, 1, 2, 3, 5, 8; then done; overflow = 1.
- start re-pulsed mid-run and n_in changed while busy -> sequence unaffected; a new start after done clears overflow.

Source files
------------

// File: rtl/fib_pkg.sv
// fib_pkg: ALU opcodes, FSM state encoding and default width for the Fibonacci sequencer
package fib_pkg;
   localparam int FIB_WIDTH = 4;
   localparam logic [2:0] OP_PASSA = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   typedef enum logic [2:0] {IDLE, CHECK, EMIT, DEC, DONE} state_t;
endpackage

// File: rtl/fib_seq_ctrl.sv
// fib_seq_ctrl: Fibonacci sequencer driving an external ALU; FIB_OVF_STOP_EN ends the run on the first carry
module fib_seq_ctrl
   import fib_pkg::*;
#(
   parameter int WIDTH = FIB_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] n_in,
   output logic [2:0]       alu_opcode,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_o,
   input  logic             alu_zero,
   output logic [WIDTH-1:0] fib_out,
   output logic             valid,
   output logic             busy,
   output logic             done,
   output logic             overflow
);
   state_t state;
   logic [WIDTH-1:0] cnt, f_prev, f_cur;
   logic carry;
   assign carry = alu_o < alu_a;
   // ALU drive registers are loaded for the state being entered, so they are valid throughout it
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         alu_opcode <= OP_PASSA;
         alu_a <= '0;
         alu_b <= '0;
         fib_out <= '0;
         valid <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         overflow <= 1'b0;
         cnt <= '0;
         f_prev <= '0;
         f_cur <= '0;
      end else begin
         valid <= 1'b0;
         done <= 1'b0;
         alu_opcode <= OP_PASSA;
         alu_a <= '0;
         alu_b <= '0;
         case (state)
            IDLE:
               if (start) begin
                  cnt <= n_in;
                  f_prev <= '0;
                  f_cur <= WIDTH'(1);
                  overflow <= 1'b0;
                  busy <= 1'b1;
                  alu_a <= n_in;
                  state <= CHECK;
               end
            CHECK:
               if (alu_zero) begin
                  done <= 1'b1;
                  state <= DONE;
               end else begin
                  valid <= 1'b1;
                  fib_out <= f_prev;
                  alu_opcode <= OP_ADD;
                  alu_a <= f_prev;
                  alu_b <= f_cur;
                  state <= EMIT;
               end
            EMIT: begin
               f_prev <= f_cur;
               f_cur <= alu_o;
               if (carry) overflow <= 1'b1;
`ifdef FIB_OVF_STOP_EN
               if (carry) begin
                  done <= 1'b1;
                  state <= DONE;
               end else begin
                  alu_opcode <= OP_SUB;
                  alu_a <= cnt;
                  alu_b <= WIDTH'(1);
                  state <= DEC;
               end
`else
               alu_opcode <= OP_SUB;
               alu_a <= cnt;
               alu_b <= WIDTH'(1);
               state <= DEC;
`endif
            end
            DEC: begin
               cnt <= alu_o;
               alu_a <= alu_o;
               state <= CHECK;
            end
            DONE: begin
               busy <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
endmodule

// File: tb/tb_fib_seq_ctrl.sv
// tb_fib_seq_ctrl: randomized run-level checks of fib_seq_ctrl against a term/timing model, with a behavioural ALU
module tb_fib_seq_ctrl;
   import fib_pkg::*;
   localparam int W = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic [W-1:0] n_in = '0;
   logic [2:0] alu_opcode;
   logic [W-1:0] alu_a, alu_b, alu_o, fib_out;
   logic alu_zero, valid, busy, done, overflow;
   int vectors = 0;
   int errors = 0;

   fib_seq_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .n_in(n_in),
      .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
      .alu_o(alu_o), .alu_zero(alu_zero),
      .fib_out(fib_out), .valid(valid), .busy(busy), .done(done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   always_comb begin
      alu_o = alu_a;
      if (alu_opcode == OP_ADD) alu_o = alu_a + alu_b;
      else if (alu_opcode == OP_SUB) alu_o = alu_a - alu_b;
      alu_zero = alu_o == '0;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_valid"}, 32'(valid), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_ovf"}, 32'(overflow), 0);
      chk({tag, "_fib"}, 32'(fib_out), 0);
      chk({tag, "_op"}, 32'(alu_opcode), 32'(OP_PASSA));
      chk({tag, "_a"}, 32'(alu_a), 0);
      chk({tag, "_b"}, 32'(alu_b), 0);
   endtask

   task automatic run(input int n);
      int terms[$];
      int a = 0, b = 1, s;
      int dc = 3 * n + 2;
      bit ovf = 1'b0;
      bit is_valid;
      for (int k = 0; k < n; k++) begin
         terms.push_back(a);
         s = a + b;
         if (s >= (1 << W)) ovf = 1'b1;
         a = b;
         b = s % (1 << W);
`ifdef FIB_OVF_STOP_EN
         if (s >= (1 << W)) begin
            dc = 3 * k + 3;
            break;
         end
`endif
      end
      @(negedge clk);
      start = 1'b1;
      n_in = W'(n);
      for (int c = 1; c <= dc + 1; c++) begin
         @(negedge clk);
         is_valid = c >= 2 && (c - 2) % 3 == 0 && (c - 2) / 3 < terms.size();
         chk("busy", 32'(busy), 32'(c <= dc));
         chk("valid", 32'(valid), 32'(is_valid));
         chk("done", 32'(done), 32'(c == dc));
         if (is_valid) chk("fib_out", 32'(fib_out), 32'(terms[(c - 2) / 3]));
         if (c % 3 == 1 && c < dc) begin
            chk("check_op", 32'(alu_opcode), 32'(OP_PASSA));
            chk("check_cnt", 32'(alu_a), 32'(n - (c - 1) / 3));
         end
         if (c == 1) chk("ovf_clr", 32'(overflow), 0);
         if (c == dc) chk("ovf_end", 32'(overflow), 32'(ovf));
         start = c <= dc ? 1'($urandom_range(0, 1)) : 1'b0;
         n_in = W'($urandom);
      end
      start = 1'b0;
   endtask

   task automatic reset_mid_run();
      @(negedge clk);
      start = 1'b1;
      n_in = 4'd7;
      repeat ($urandom_range(2, 12)) @(negedge clk);
      start = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk_idle_outputs("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("post_rst_done", 32'(done), 0);
         chk("post_rst_busy", 32'(busy), 0);
      end
   endtask

   initial begin
      #2 chk_idle_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      run(3);
      run(0);
      run(10);
      run(10);
      run(1);
      run(15);
      for (int i = 0; i < 8; i++) run(int'($urandom_range(0, 15)));
      reset_mid_run();
      run(5);
      reset_mid_run();
      run(10);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
